// File: rtl/nexys_starship_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nexys_starship_pkg
// Purpose  : Shared types and constants for the Nexys Starship room logic:
//            one-hot room state encoding, LFSR feedback taps and the
//            seven-segment code type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nexys_starship_pkg;

    // One-hot room state; bit positions map straight onto q_Init/q_Working/q_Repair
    typedef enum logic [2:0] {
        ST_INIT    = 3'b001,
        ST_WORKING = 3'b010,
        ST_REPAIR  = 3'b100
    } room_state_t;

    // x^4 + x^3 + 1 : feedback is the XOR of bits 3 and 2
    localparam logic [3:0] c_lfsr_taps = 4'b1100;

    // Code shown on one SSD digit
    typedef logic [3:0] ssd_code_t;

endpackage
`default_nettype wire

// File: rtl/nexys_starship_room_repair_if.sv
`default_nettype none
// ============================================================================
// Module   : nexys_starship_room_repair_if
// Purpose  : Bundles the per-room game inputs (play/game-over flags, damage,
//            submit, switch combo) and the room status outputs.
// Ports    : master - game/top-level side, drives inputs, reads status
//            slave  - room repair block side
// Revision : 1.0 - initial release
// ============================================================================
interface nexys_starship_room_repair_if;
    import nexys_starship_pkg::*;

    logic      play_flag;
    logic      game_over;
    logic      damage;
    logic      submit;
    ssd_code_t combo_in;

    logic      q_Init;
    logic      q_Working;
    logic      q_Repair;
    logic      broken;
    ssd_code_t repair_combo;
    logic [3:0] miss_count;
    logic      warn;
    logic      fail;

    modport master (
        output play_flag, game_over, damage, submit, combo_in,
        input  q_Init, q_Working, q_Repair, broken, repair_combo, miss_count, warn, fail
    );

    modport slave (
        input  play_flag, game_over, damage, submit, combo_in,
        output q_Init, q_Working, q_Repair, broken, repair_combo, miss_count, warn, fail
    );

endinterface
`default_nettype wire

// File: rtl/nexys_starship_lfsr4.sv
`default_nettype none
// ============================================================================
// Module   : nexys_starship_lfsr4
// Purpose  : 4-bit Fibonacci LFSR (x^4 + x^3 + 1), period 15, never zero
//            when seeded nonzero. Shared by room repair and monster spawn.
// Ports    : clk, rst_n (async active-low), en (advance), q (current value)
// Revision : 1.0 - initial release
// ============================================================================
module nexys_starship_lfsr4
    import nexys_starship_pkg::*;
#(
    parameter logic [3:0] SEED = 4'b1001
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    output ssd_code_t q
);

    ssd_code_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {r_q[2:0], ^(r_q & c_lfsr_taps)};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/nexys_starship_room_repair.sv
`default_nettype none
// ============================================================================
// Module   : nexys_starship_room_repair
// Purpose  : Per-room damage/repair state machine. A monster hit breaks the
//            room and latches a random repair code; the player must enter it
//            on the switches and press submit before the timer runs out or
//            before MAX_MISSES wrong attempts, otherwise the sticky fail flag
//            is raised.
// Ports    : Clk, Reset_n (async active-low), rr (interface, slave side):
//            play_flag, game_over, damage, submit, combo_in in;
//            q_Init/q_Working/q_Repair, broken, repair_combo, miss_count,
//            warn, fail out (all registered).
// Revision : 1.0 - initial release
// ============================================================================
module nexys_starship_room_repair
    import nexys_starship_pkg::*;
#(
    parameter int unsigned REPAIR_CYCLES = 1_000_000_000,
    parameter int unsigned TIMER_W       = 30,
    parameter int unsigned MAX_MISSES    = 3,
    parameter logic [3:0]  LFSR_SEED     = 4'b1001
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    nexys_starship_room_repair_if.slave rr
);

    localparam logic [TIMER_W-1:0] c_timer_load = TIMER_W'(REPAIR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_warn_level = TIMER_W'(REPAIR_CYCLES / 4);
    localparam logic [3:0]         c_max_misses = 4'(MAX_MISSES);

    room_state_t        r_state;
    ssd_code_t          r_repair_combo;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_miss_count;
    logic               r_warn;
    logic               r_fail;

    ssd_code_t          w_lfsr;
    logic               w_correct;
    logic [3:0]         w_miss_next;
    logic               w_warn_now;

    nexys_starship_lfsr4 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (1'b1),
        .q     (w_lfsr)
    );

    assign w_correct   = rr.submit && (rr.combo_in == r_repair_combo);
    assign w_miss_next = r_miss_count + 4'd1;
    assign w_warn_now  = (r_timer < c_warn_level);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= ST_INIT;
            r_repair_combo <= '0;
            r_timer        <= '0;
            r_miss_count   <= '0;
            r_warn         <= 1'b0;
            r_fail         <= 1'b0;
        end else if (rr.game_over) begin
            r_state        <= ST_INIT;
            r_repair_combo <= '0;
            r_timer        <= '0;
            r_miss_count   <= '0;
            r_warn         <= 1'b0;
            r_fail         <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (rr.play_flag) begin
                        r_state <= ST_WORKING;
                    end
                end
                ST_WORKING: begin
                    if (rr.damage) begin
                        r_state        <= ST_REPAIR;
                        r_repair_combo <= w_lfsr;
                        r_timer        <= c_timer_load;
                        r_miss_count   <= '0;
                        r_warn         <= 1'b0;
                    end
                end
                ST_REPAIR: begin
                    if (r_fail) begin
                        // Room lost: timer stays frozen, inputs ignored
                        r_warn <= w_warn_now;
                    end else if (w_correct) begin
                        // A correct code wins even on the timer-0 cycle
                        r_state        <= ST_WORKING;
                        r_repair_combo <= '0;
                        r_timer        <= '0;
                        r_warn         <= 1'b0;
                    end else begin
                        r_warn <= w_warn_now;
                        if (r_timer == '0) begin
                            r_fail <= 1'b1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                        if (rr.submit) begin
                            r_miss_count <= w_miss_next;
                            if (w_miss_next == c_max_misses) begin
                                r_fail <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // State outputs come straight from the one-hot flops
    assign rr.q_Init       = r_state[0];
    assign rr.q_Working    = r_state[1];
    assign rr.q_Repair     = r_state[2];
    assign rr.broken       = r_state[2];
    assign rr.repair_combo = r_repair_combo;
    assign rr.miss_count   = r_miss_count;
    assign rr.warn         = r_warn;
    assign rr.fail         = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_room_repair.sv
`default_nettype none
// ============================================================================
// Module   : tb_nexys_starship_room_repair
// Purpose  : Directed self-checking bench for nexys_starship_room_repair
//            with REPAIR_CYCLES=20, MAX_MISSES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_room_repair;

    localparam int unsigned REPAIR_CYCLES = 20;
    localparam logic [3:0]  SEED          = 4'b1001;

    // flag vector order: {q_Init, q_Working, q_Repair, broken, warn, fail}
    localparam logic [5:0] F_INIT    = 6'b100000;
    localparam logic [5:0] F_WORKING = 6'b010000;
    localparam logic [5:0] F_REPAIR  = 6'b001100;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [3:0] m_lfsr;
    logic [5:0] flags;

    nexys_starship_room_repair_if bus ();

    nexys_starship_room_repair #(
        .REPAIR_CYCLES (REPAIR_CYCLES),
        .TIMER_W       (5),
        .MAX_MISSES    (3),
        .LFSR_SEED     (SEED)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .rr      (bus)
    );

    assign flags = {bus.q_Init, bus.q_Working, bus.q_Repair, bus.broken, bus.warn, bus.fail};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: x^4+x^3+1, shift left, feedback q3^q2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.play_flag = 1'b0; bus.game_over = 1'b0; bus.damage = 1'b0;
        bus.submit = 1'b0; bus.combo_in = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (flags !== F_INIT) begin failures++; $display("FAIL reset_flags: got %b expected %b", flags, F_INIT); end
        checks++;
        if ({bus.repair_combo, bus.miss_count} !== 8'h00) begin failures++; $display("FAIL reset_values: got %h expected 00", {bus.repair_combo, bus.miss_count}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (flags !== F_INIT) begin failures++; $display("FAIL init_hold: got %b expected %b", flags, F_INIT); end
        bus.play_flag = 1'b1;
        @(negedge clk);
        checks++;
        if (flags !== F_WORKING) begin failures++; $display("FAIL start_working: got %b expected %b", flags, F_WORKING); end
    endtask

    task automatic test_correct_repair();
        logic [3:0] exp;
        // submit in WORKING is ignored
        bus.submit = 1'b1; bus.combo_in = 4'h0;
        @(negedge clk);
        bus.submit = 1'b0;
        checks++;
        if ({flags, bus.miss_count} !== {F_WORKING, 4'd0}) begin failures++; $display("FAIL submit_in_working: got %b expected %b", {flags, bus.miss_count}, {F_WORKING, 4'd0}); end
        exp = m_lfsr;
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        checks++;
        if (flags !== F_REPAIR) begin failures++; $display("FAIL damage_flags: got %b expected %b", flags, F_REPAIR); end
        checks++;
        if (bus.repair_combo !== exp) begin failures++; $display("FAIL damage_combo: got %h expected %h", bus.repair_combo, exp); end
        repeat (4) @(negedge clk);
        bus.combo_in = exp; bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
        checks++;
        if (flags !== F_WORKING) begin failures++; $display("FAIL repair_flags: got %b expected %b", flags, F_WORKING); end
        checks++;
        if (bus.repair_combo !== 4'h0) begin failures++; $display("FAIL repair_combo_clear: got %h expected 0", bus.repair_combo); end
    endtask

    task automatic test_timeout();
        logic [3:0] exp;
        logic [5:0] want;
        exp = m_lfsr;
        bus.damage = 1'b1;
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            bus.damage = 1'b0;
            want = F_REPAIR | {4'b0000, (j >= 17), (j >= 21)};
            checks++;
            if (flags !== want) begin failures++; $display("FAIL timeout_cycle_%0d: got %b expected %b", j, flags, want); end
        end
        // failed room ignores a correct submit and further damage
        bus.combo_in = exp; bus.submit = 1'b1; bus.damage = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0; bus.damage = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({flags, bus.repair_combo} !== {6'b001111, exp}) begin failures++; $display("FAIL timeout_sticky: got %b expected %b", {flags, bus.repair_combo}, {6'b001111, exp}); end
        bus.game_over = 1'b1;
        @(negedge clk);
        bus.game_over = 1'b0;
        checks++;
        if ({flags, bus.repair_combo, bus.miss_count} !== {F_INIT, 8'h00}) begin failures++; $display("FAIL game_over_clear: got %b expected %b", {flags, bus.repair_combo, bus.miss_count}, {F_INIT, 8'h00}); end
        @(negedge clk);
        checks++;
        if (flags !== F_WORKING) begin failures++; $display("FAIL restart_working: got %b expected %b", flags, F_WORKING); end
    endtask

    task automatic test_timer0_submit();
        logic [3:0] exp;
        exp = m_lfsr;
        bus.damage = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            bus.damage = 1'b0;
        end
        checks++;
        if (flags !== 6'b001110) begin failures++; $display("FAIL timer0_before: got %b expected 001110", flags); end
        bus.combo_in = exp; bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
        checks++;
        if ({flags, bus.repair_combo} !== {F_WORKING, 4'h0}) begin failures++; $display("FAIL timer0_submit: got %b expected %b", {flags, bus.repair_combo}, {F_WORKING, 4'h0}); end
    endtask

    task automatic test_misses();
        logic [3:0] exp;
        exp = m_lfsr;
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.combo_in = 4'h0; bus.submit = 1'b1;
            @(negedge clk);
            bus.submit = 1'b0;
            checks++;
            if (bus.miss_count !== 4'(k)) begin failures++; $display("FAIL miss_count_%0d: got %0d expected %0d", k, bus.miss_count, k); end
            checks++;
            if (bus.fail !== (k == 3)) begin failures++; $display("FAIL miss_fail_%0d: got %b expected %b", k, bus.fail, (k == 3)); end
            @(negedge clk);
        end
        bus.combo_in = exp; bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
        checks++;
        if ({flags, bus.repair_combo, bus.miss_count} !== {6'b001101, exp, 4'd3}) begin failures++; $display("FAIL miss_late_submit: got %b expected %b", {flags, bus.repair_combo, bus.miss_count}, {6'b001101, exp, 4'd3}); end
        bus.game_over = 1'b1;
        @(negedge clk);
        bus.game_over = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_damage_in_repair();
        logic [3:0] exp;
        exp = m_lfsr;
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        @(negedge clk);
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        checks++;
        if ({flags, bus.repair_combo} !== {F_REPAIR, exp}) begin failures++; $display("FAIL damage_in_repair: got %b expected %b", {flags, bus.repair_combo}, {F_REPAIR, exp}); end
        bus.combo_in = exp; bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
    endtask

    task automatic test_game_over_submit();
        logic [3:0] exp;
        exp = m_lfsr;
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        bus.game_over = 1'b1; bus.combo_in = exp; bus.submit = 1'b1;
        @(negedge clk);
        bus.game_over = 1'b0; bus.submit = 1'b0;
        checks++;
        if ({flags, bus.repair_combo} !== {F_INIT, 4'h0}) begin failures++; $display("FAIL game_over_priority: got %b expected %b", {flags, bus.repair_combo}, {F_INIT, 4'h0}); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        bus.combo_in = 4'h0; bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({flags, bus.repair_combo, bus.miss_count} !== {F_INIT, 8'h00}) begin failures++; $display("FAIL async_reset: got %b expected %b", {flags, bus.repair_combo, bus.miss_count}, {F_INIT, 8'h00}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // one clock since release: seed 9 has advanced to 3
        bus.damage = 1'b1;
        @(negedge clk);
        bus.damage = 1'b0;
        checks++;
        if ({flags, bus.repair_combo} !== {F_REPAIR, 4'h3}) begin failures++; $display("FAIL lfsr_restart: got %b expected %b", {flags, bus.repair_combo}, {F_REPAIR, 4'h3}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_correct_repair();
        test_timeout();
        test_timer0_submit();
        test_misses();
        test_damage_in_repair();
        test_game_over_submit();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nexys_starship_room_repair.md
# nexys_starship_room_repair

Per-room damage/repair state machine for the Nexys Starship game, one instance per room (top, bottom, left, right). It sits directly downstream of the monster state machines and the top-level switch/button input stage. It consumes a monster-hit pulse, the debounced centre-button pulse and the switch combo, and produces the room's broken flag and the secret repair code shown on the SSD. It also produces a sticky `fail` that the game state machine ORs into `game_over`.

## Interface
Parameters:
- `REPAIR_CYCLES`, default 1_000_000_000: repair window in clock cycles (10 s at 100 MHz); ≥2.
- `TIMER_W`, default 30: timer width; must hold `REPAIR_CYCLES-1`.
- `MAX_MISSES`, default 3: wrong submissions allowed before fail; 1..15.
- `LFSR_SEED`, default 4'b1001: LFSR reset value; nonzero.

Ports (clock and reset first):
- `Clk`  in  1: system clock, 100 MHz.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `play_flag`  in  1: game in Play state.
- `game_over`  in  1: game ended; returns block to Init.
- `damage`  in  1: one-cycle pulse, monster hit this room.
- `submit`  in  1: one-cycle pulse, debounced centre button.
- `combo_in`  in  4: switch value {Sw3..Sw0}.
- `q_Init`, `q_Working`, `q_Repair`  out  1 each: one-hot state.
- `broken`  out  1: room broken (equals `q_Repair`).
- `repair_combo`  out  4: code required to repair; 0 when not broken.
- `miss_count`  out  4: wrong submissions in the current repair.
- `warn`  out  1: in Repair and timer < `REPAIR_CYCLES/4`.
- `fail`  out  1: sticky, room lost.

## Operation
- **LFSR:** a 4-bit Fibonacci LFSR with polynomial x^4+x^3+1 free-runs every cycle from `LFSR_SEED`. Its period is 15, so its value is never 0.
- **INIT:** `play_flag` and !`game_over` → WORKING.
- **WORKING:**
  - `damage` → REPAIR.
  - On entry: `repair_combo` ← LFSR current value; timer ← `REPAIR_CYCLES-1`; `miss_count` ← 0.
- **REPAIR, not failed:**
  - Each cycle the timer decrements.
  - `submit` with `combo_in == repair_combo` → WORKING, and `repair_combo` ← 0.
  - `submit` with a mismatch → `miss_count`+1. If the new count equals `MAX_MISSES`, then `fail` ← 1.
  - Timer at 0 without a correct submit → `fail` ← 1.
- **REPAIR, failed:**
  - The block stays in REPAIR and the timer freezes.
  - `submit` and `damage` are ignored.
- **Any state:** `game_over` → INIT, and all outputs return to reset values.
- **Priority:**
  1. `game_over`
  2. correct `submit`
  3. timer expiry or `MAX_MISSES`-th miss
  4. other events
- **Ignored inputs:**
  - `damage` in REPAIR or INIT is ignored.
  - `submit` outside REPAIR is ignored.
  - A correct `submit` on the same cycle the timer reads 0 repairs the room; no fail.
- **Reset values:** `q_Init`=1; all other outputs 0; LFSR=`LFSR_SEED`; timer=0.
- **Reset mid-repair:** aborts immediately to reset values, asynchronously.

## Timing
- All outputs are registered, with no combinational input→output path.
- `damage` high in cycle n (WORKING) → `q_Repair`, `broken` and `repair_combo` valid in cycle n+1. `repair_combo` equals the LFSR value sampled in cycle n.
- No correct submit → `fail` rises in cycle n+1+`REPAIR_CYCLES`.
- Correct `submit` in cycle m → `q_Working`=1 and `repair_combo`=0 in cycle m+1.
- `MAX_MISSES`-th wrong `submit` in cycle m → `fail`=1 in cycle m+1.
- `game_over` in cycle m → `q_Init`=1 in cycle m+1.
- `warn` is registered: it asserts the cycle after the timer falls below `REPAIR_CYCLES/4`, using integer division.

## Structure
- The shared package `nexys_starship_pkg` holds:
  - the room state encoding (INIT/WORKING/REPAIR, one-hot, 3 bits);
  - the LFSR tap constant;
  - the SSD code type `[3:0]`.
- Sub-module `nexys_starship_lfsr4` (seed parameter, enable tied high, 4-bit out) is shared with the monster spawn logic.
- The timer and miss counter are inline.

## Test plan
All scenarios use `REPAIR_CYCLES`=20 and `MAX_MISSES`=3.
- **Reset and start:** `Reset_n`=0 → `q_Init`=1, all else 0. `play_flag`=1 → `q_Working`=1 next cycle.
- **Correct repair:** `damage` pulse → `repair_combo` = model LFSR value (e.g. 4'hC), `broken`=1. `submit` with `combo_in`=4'hC at cycle 5 → `q_Working`=1 and `repair_combo`=0 next cycle; `fail` stays 0.
- **Timeout:** `damage`, no submit → `warn`=1 from cycle n+17; `fail`=1 exactly at cycle n+21, with the state held in REPAIR.
- **Misses:** three wrong submits (`combo_in`=0) → `miss_count` 1, 2, 3 and `fail`=1 after the third. A later correct submit leaves the block in REPAIR.
- **Corner cases:**
  - correct `submit` on the timer-0 cycle → WORKING, `fail`=0;
  - `damage` during REPAIR → `repair_combo` unchanged;
  - `game_over` coinciding with a correct `submit` → INIT.
- **Mid-repair reset:** assert `Reset_n`=0 mid-repair → outputs return to reset values asynchronously. After release, the LFSR restarts at `LFSR_SEED`.
